// File: rtl/reset_request_seq.sv
// Reset request sequencer: arbitrates software requests and a kickable watchdog
// into a fixed-length ASSERT_OUT pulse followed by a refusal (cooldown) window.
module reset_request_seq #(
    parameter int LEN_W       = 8,
    parameter int DEFAULT_LEN = 4,
    parameter int COOLDOWN    = 8,
    parameter int WDOG_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    input  logic [LEN_W-1:0]  REQ_LEN,
    output logic              REQ_READY,
    input  logic              WDOG_EN,
    input  logic [WDOG_W-1:0] WDOG_LIMIT,
    input  logic              WDOG_KICK,
    output logic              ASSERT_OUT,
    output logic              BUSY,
    output logic [1:0]        CAUSE,
    input  logic              CAUSE_CLR,
    output logic [7:0]        RST_COUNT
);

    localparam int                CW      = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [LEN_W-1:0]  DEF_LEN = LEN_W'(DEFAULT_LEN);
    localparam logic [CW-1:0]     COOL_LD = CW'(COOLDOWN);
    localparam logic [WDOG_W-1:0] WD_ONE  = WDOG_W'(1);

    typedef enum logic [1:0] {IDLE, ASSERT, COOL} state_t;

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [CW-1:0]     cool_cnt;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_on;
    logic              wdog_exp;

    assign wdog_on   = WDOG_EN && (WDOG_LIMIT != '0);
    // >= rather than == so a limit lowered below the running count still fires
    assign wdog_exp  = wdog_on && !WDOG_KICK && (wdog_cnt >= WDOG_LIMIT - WD_ONE);
    assign REQ_READY = (state == IDLE) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            cool_cnt   <= '0;
            wdog_cnt   <= '0;
            ASSERT_OUT <= 1'b0;
            BUSY       <= 1'b0;
            CAUSE      <= 2'b00;
            RST_COUNT  <= 8'd0;
        end else begin
            // a cause set later in this block overrides the clear
            if (CAUSE_CLR)
                CAUSE <= 2'b00;
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        state      <= ASSERT;
                        ASSERT_OUT <= 1'b1;
                        BUSY       <= 1'b1;
                        cnt        <= (REQ_LEN == '0) ? DEF_LEN : REQ_LEN;
                        CAUSE      <= 2'b01;
                        wdog_cnt   <= '0;
                    end else if (wdog_exp) begin
                        state      <= ASSERT;
                        ASSERT_OUT <= 1'b1;
                        BUSY       <= 1'b1;
                        cnt        <= DEF_LEN;
                        CAUSE      <= 2'b10;
                        wdog_cnt   <= '0;
                    end else if (!wdog_on || WDOG_KICK) begin
                        wdog_cnt <= '0;
                    end else begin
                        wdog_cnt <= wdog_cnt + WD_ONE;
                    end
                end
                ASSERT: begin
                    wdog_cnt <= '0;
                    if (cnt == LEN_W'(1)) begin
                        ASSERT_OUT <= 1'b0;
                        cnt        <= '0;
                        if (RST_COUNT != 8'hFF)
                            RST_COUNT <= RST_COUNT + 8'd1;
                        if (COOLDOWN == 0) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state    <= COOL;
                            cool_cnt <= COOL_LD;
                        end
                    end else begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                COOL: begin
                    wdog_cnt <= '0;
                    if (cool_cnt <= CW'(1)) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        cool_cnt <= '0;
                    end else begin
                        cool_cnt <= cool_cnt - CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    ASSERT_OUT <= 1'b0;
                    BUSY       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_request_seq.sv
// Directed bench for reset_request_seq: a per-cycle vector table followed by
// hand-written multi-cycle sequences (watchdog, arbitration, mid-pulse reset, saturation).
module tb_reset_request_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic [7:0]  REQ_LEN = 8'd0;
    logic        REQ_READY;
    logic        WDOG_EN = 1'b0;
    logic [15:0] WDOG_LIMIT = 16'd0;
    logic        WDOG_KICK = 1'b0;
    logic        ASSERT_OUT;
    logic        BUSY;
    logic [1:0]  CAUSE;
    logic        CAUSE_CLR = 1'b0;
    logic [7:0]  RST_COUNT;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    reset_request_seq dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_LEN(REQ_LEN),
        .REQ_READY(REQ_READY), .WDOG_EN(WDOG_EN), .WDOG_LIMIT(WDOG_LIMIT),
        .WDOG_KICK(WDOG_KICK), .ASSERT_OUT(ASSERT_OUT), .BUSY(BUSY),
        .CAUSE(CAUSE), .CAUSE_CLR(CAUSE_CLR), .RST_COUNT(RST_COUNT)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] len;
        logic       clr;
        logic       e_asrt;
        logic       e_rdy;
        logic       e_busy;
        logic [1:0] e_cause;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && BUSY; i++) tick();
        chk("idle_reached", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int acc;
        // rst vld len clr | asrt rdy busy cause cnt
        tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
        tbl[3] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd0};
        tbl[5] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1};
        tbl[7] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};
        tbl[8] = '{1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};

        for (int v = 0; v < 9; v++) begin
            RST = tbl[v].rst; REQ_VALID = tbl[v].vld; REQ_LEN = tbl[v].len; CAUSE_CLR = tbl[v].clr;
            tick();
            chk($sformatf("tbl%0d_assert", v), {31'd0, ASSERT_OUT}, {31'd0, tbl[v].e_asrt});
            chk($sformatf("tbl%0d_ready", v),  {31'd0, REQ_READY},  {31'd0, tbl[v].e_rdy});
            chk($sformatf("tbl%0d_busy", v),   {31'd0, BUSY},       {31'd0, tbl[v].e_busy});
            chk($sformatf("tbl%0d_cause", v),  {30'd0, CAUSE},      {30'd0, tbl[v].e_cause});
            chk($sformatf("tbl%0d_count", v),  {24'd0, RST_COUNT},  {24'd0, tbl[v].e_cnt});
        end
        REQ_VALID = 1'b0; REQ_LEN = 8'd0; CAUSE_CLR = 1'b0;

        // post-reset quiescence
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("quiet_assert", {31'd0, ASSERT_OUT}, 32'd0);
            chk("quiet_ready",  {31'd0, REQ_READY},  32'd1);
            chk("quiet_cause",  {30'd0, CAUSE},      32'd0);
            chk("quiet_count",  {24'd0, RST_COUNT},  32'd0);
        end

        // explicit length 5: 5 high samples, ready low for 5+8 samples
        REQ_VALID = 1'b1; REQ_LEN = 8'd5;
        tick();
        REQ_VALID = 1'b0; REQ_LEN = 8'd0;
        for (int i = 0; i < 16; i++) begin
            chk("len5_assert", {31'd0, ASSERT_OUT}, {31'd0, (i < 5)});
            chk("len5_ready",  {31'd0, REQ_READY},  {31'd0, (i >= 13)});
            tick();
        end
        chk("len5_cause", {30'd0, CAUSE},     32'd1);
        chk("len5_count", {24'd0, RST_COUNT}, 32'd1);

        // default length, REQ_VALID held: second accept after 8 cool + 1 idle cycle
        REQ_VALID = 1'b1; REQ_LEN = 8'd0;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("b2b_assert", {31'd0, ASSERT_OUT}, {31'd0, (i < 4) || (i >= 13 && i < 17)});
            if (i == 12) chk("b2b_ready_gap", {31'd0, REQ_READY}, 32'd1);
            if (i < 20 - 1) tick();
        end
        REQ_VALID = 1'b0;
        chk("b2b_count", {24'd0, RST_COUNT}, 32'd3);
        wait_idle();

        // watchdog expiry after 10 idle cycles
        WDOG_EN = 1'b1; WDOG_LIMIT = 16'd10;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("wd_assert", {31'd0, ASSERT_OUT}, {31'd0, (i >= 9 && i < 13)});
            if (i == 8) chk("wd_cause_before", {30'd0, CAUSE}, 32'd1);
            if (i == 9) chk("wd_cause", {30'd0, CAUSE}, 32'd2);
        end
        WDOG_EN = 1'b0;
        wait_idle();
        chk("wd_count", {24'd0, RST_COUNT}, 32'd4);

        // kicked every 8 cycles: never expires
        WDOG_EN = 1'b1;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            WDOG_KICK = (i % 8 == 7);
            tick();
            if (ASSERT_OUT) acc++;
        end
        WDOG_KICK = 1'b0; WDOG_EN = 1'b0;
        chk("kick_no_pulse", acc, 32'd0);
        tick();

        // software request coincides with expiry and CAUSE_CLR
        WDOG_EN = 1'b1; WDOG_LIMIT = 16'd10;
        for (int i = 0; i < 9; i++) tick();
        chk("sim_pre_assert", {31'd0, ASSERT_OUT}, 32'd0);
        REQ_VALID = 1'b1; REQ_LEN = 8'd0; CAUSE_CLR = 1'b1;
        tick();
        REQ_VALID = 1'b0; CAUSE_CLR = 1'b0; WDOG_EN = 1'b0;
        chk("sim_assert", {31'd0, ASSERT_OUT}, 32'd1);
        chk("sim_cause",  {30'd0, CAUSE},      32'd1);
        chk("sim_count0", {24'd0, RST_COUNT},  32'd4);
        repeat (4) tick();
        chk("sim_end_assert", {31'd0, ASSERT_OUT}, 32'd0);
        chk("sim_count1",     {24'd0, RST_COUNT},  32'd5);
        wait_idle();
        chk("sim_cause_kept", {30'd0, CAUSE},     32'd1);
        chk("sim_count2",     {24'd0, RST_COUNT}, 32'd5);

        // reset on cycle 2 of a 10-cycle pulse
        REQ_VALID = 1'b1; REQ_LEN = 8'd10;
        tick();
        REQ_VALID = 1'b0;
        tick();
        chk("mid_assert_c2", {31'd0, ASSERT_OUT}, 32'd1);
        RST = 1'b1;
        tick();
        chk("mid_assert_rst", {31'd0, ASSERT_OUT}, 32'd0);
        chk("mid_busy_rst",   {31'd0, BUSY},       32'd0);
        chk("mid_ready_rst",  {31'd0, REQ_READY},  32'd0);
        RST = 1'b0;
        #1;
        chk("mid_ready_rel", {31'd0, REQ_READY}, 32'd1);
        chk("mid_count",     {24'd0, RST_COUNT}, 32'd0);

        // 260 accepted requests saturate RST_COUNT
        REQ_VALID = 1'b1; REQ_LEN = 8'd1;
        acc = 0;
        for (int c = 0; c < 6000 && acc < 260; c++) begin
            if (REQ_READY) acc++;
            tick();
        end
        REQ_VALID = 1'b0;
        chk("sat_accepts", acc, 32'd260);
        wait_idle();
        chk("sat_count", {24'd0, RST_COUNT}, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
